// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, ALU op codes and forward select codes for ex_stage
package ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_SLLV = 4'd11,
        ALU_SRLV = 4'd12,
        ALU_SRAV = 4'd13,
        ALU_LUI  = 4'd14,
        ALU_ZERO = 4'd15
    } alu_op_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Code 11 is unused by the forwarding unit and falls back to the register file.
    function automatic logic [DATA_W-1:0] fwd_select(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf_val,
        input logic [DATA_W-1:0] exmem_val,
        input logic [DATA_W-1:0] memwb_val
    );
        case (sel)
            FWD_EXMEM: fwd_select = exmem_val;
            FWD_MEMWB: fwd_select = memwb_val;
            default:   fwd_select = rf_val;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational ALU used by the execute stage
module alu
    import ex_stage_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_SLLV: result = b << a[4:0];
            ALU_SRLV: result = b >> a[4:0];
            ALU_SRAV: result = $signed(b) >>> a[4:0];
            ALU_LUI:  result = {b[15:0], 16'h0000};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU and the EX/MEM pipeline register
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_forward_a,
    input  logic [1:0]        i_forward_b,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [4:0]        i_shamt,
    input  logic [3:0]        i_alu_op,
    input  logic              i_alu_src,
    input  logic [REG_W-1:0]  i_rd,
    input  logic              i_regwrite,
    input  logic              i_memread,
    input  logic              i_memwrite,
    input  logic              i_memtoreg,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_store_data,
    output logic [REG_W-1:0]  o_rd,
    output logic              o_regwrite,
    output logic              o_memread,
    output logic              o_memwrite,
    output logic              o_memtoreg
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_out;

    // EX/MEM forwarding reads the registered result, so a held register keeps feeding back.
    assign op_a   = fwd_select(i_forward_a, i_rs_data, o_alu_result, i_wb_data);
    assign fwd_rt = fwd_select(i_forward_b, i_rt_data, o_alu_result, i_wb_data);
    assign op_b   = i_alu_src ? i_imm : fwd_rt;

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .shamt  (i_shamt),
        .op     (i_alu_op),
        .result (alu_out)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            o_alu_result <= '0;
            o_store_data <= '0;
            o_rd         <= '0;
            o_regwrite   <= 1'b0;
            o_memread    <= 1'b0;
            o_memwrite   <= 1'b0;
            o_memtoreg   <= 1'b0;
        end else if (!i_stall) begin
            o_alu_result <= alu_out;
            o_store_data <= fwd_rt;
            o_rd         <= i_rd;
            o_regwrite   <= i_regwrite;
            o_memread    <= i_memread;
            o_memwrite   <= i_memwrite;
            o_memtoreg   <= i_memtoreg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage: directed vectors, corner sequences, random model
module tb_ex_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  i_forward_a, i_forward_b;
    logic [31:0] i_rs_data, i_rt_data, i_imm, i_wb_data;
    logic [4:0]  i_shamt;
    logic [3:0]  i_alu_op;
    logic        i_alu_src;
    logic [4:0]  i_rd;
    logic        i_regwrite, i_memread, i_memwrite, i_memtoreg;
    logic        i_stall, i_flush;
    logic [31:0] o_alu_result, o_store_data;
    logic [4:0]  o_rd;
    logic        o_regwrite, o_memread, o_memwrite, o_memtoreg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_alu, m_store;
    logic [4:0]  m_rd;
    logic [3:0]  m_ctl;

    ex_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_forward_a(i_forward_a), .i_forward_b(i_forward_b),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_wb_data(i_wb_data),
        .i_shamt(i_shamt), .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_rd(i_rd),
        .i_regwrite(i_regwrite), .i_memread(i_memread), .i_memwrite(i_memwrite), .i_memtoreg(i_memtoreg),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_alu_result(o_alu_result), .o_store_data(o_store_data), .o_rd(o_rd),
        .o_regwrite(o_regwrite), .o_memread(o_memread), .o_memwrite(o_memwrite), .o_memtoreg(o_memtoreg)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [31:0] rs, rt, imm, wb;
        logic [4:0]  shamt;
        logic [3:0]  op;
        logic        src;
        logic [4:0]  rd;
        logic [31:0] exp_alu, exp_store;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] pow2(input int s);
        logic [31:0] p;
        p = 32'd1;
        for (int k = 0; k < s; k++) p = p * 32'd2;
        return p;
    endfunction

    // Reference ALU written arithmetically: shifts as multiply/divide by powers of two.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        int          sa, sb, s;
        logic [63:0] prod;
        sa = a; sb = b;
        s  = (op >= 4'd11 && op <= 4'd13) ? int'(a % 32) : int'(sh);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b + 32'd1);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8, 4'd11: begin prod = {32'd0, b} * {32'd0, pow2(s)}; return prod[31:0]; end
            4'd9, 4'd12: return b / pow2(s);
            4'd10, 4'd13: return (sb < 0) ? ~((~b) / pow2(s)) : b / pow2(s);
            4'd14: begin prod = {32'd0, b} * 64'd65536; return prod[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_sel(input logic [1:0] c, input logic [31:0] rf,
                                            input logic [31:0] prev, input logic [31:0] wb);
        if (c == 2'b10) return prev;
        if (c == 2'b01) return wb;
        return rf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_check(input string tag);
        @(posedge i_clk);
        #1;
        chk({tag, " alu"},   o_alu_result, m_alu);
        chk({tag, " store"}, o_store_data, m_store);
        chk({tag, " rd"},    {27'd0, o_rd}, {27'd0, m_rd});
        chk({tag, " ctl"},   {28'd0, o_regwrite, o_memread, o_memwrite, o_memtoreg}, {28'd0, m_ctl});
    endtask

    task automatic set_zero_model();
        m_alu = '0; m_store = '0; m_rd = '0; m_ctl = '0;
    endtask

    task automatic apply_vec(input vec_t v, input logic [3:0] ctl);
        i_forward_a = v.fa; i_forward_b = v.fb;
        i_rs_data = v.rs; i_rt_data = v.rt; i_imm = v.imm; i_wb_data = v.wb;
        i_shamt = v.shamt; i_alu_op = v.op; i_alu_src = v.src; i_rd = v.rd;
        {i_regwrite, i_memread, i_memwrite, i_memtoreg} = ctl;
    endtask

    initial begin
        logic [31:0] a, rtf, b;
        logic        rst, fl, st;
        vecs[0] = '{2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 5'd1, 32'd12, 32'd7};
        vecs[1] = '{2'b10, 2'b00, 32'd100, 32'd3, 32'd0, 32'd0, 5'd0, 4'd1, 1'b0, 5'd2, 32'd9, 32'd3};
        vecs[2] = '{2'b00, 2'b01, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 4'd6, 1'b0, 5'd3, 32'd0, 32'hFFFF_FFFF};
        vecs[3] = '{2'b00, 2'b01, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 4'd7, 1'b0, 5'd4, 32'd1, 32'hFFFF_FFFF};
        vecs[4] = '{2'b00, 2'b00, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 5'd4, 4'd10, 1'b0, 5'd5, 32'hF800_0000, 32'h8000_0000};
        vecs[5] = '{2'b00, 2'b00, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 5'd4, 4'd9, 1'b0, 5'd6, 32'h0800_0000, 32'h8000_0000};
        vecs[6] = '{2'b00, 2'b00, 32'd33, 32'h8000_0000, 32'd0, 32'd0, 5'd4, 4'd11, 1'b0, 5'd7, 32'h0000_0000, 32'h8000_0000};
        vecs[7] = '{2'b00, 2'b00, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 5'd8, 32'h8000_0000, 32'd1};
        vecs[8] = '{2'b00, 2'b00, 32'd9, 32'd55, 32'h0000_1234, 32'd0, 5'd0, 4'd14, 1'b1, 5'd9, 32'h1234_0000, 32'd55};

        i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        apply_vec(vecs[0], 4'hF);
        set_zero_model();
        tick_check("reset");
        i_stall = 1'b1; i_flush = 1'b1;
        tick_check("reset_ovr");
        i_rst_n = 1'b1; i_stall = 1'b0; i_flush = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply_vec(vecs[i], 4'(i + 3));
            m_alu = vecs[i].exp_alu; m_store = vecs[i].exp_store;
            m_rd = vecs[i].rd; m_ctl = 4'(i + 3);
            tick_check($sformatf("vec%0d", i));
        end

        // Stall with changing inputs, EX/MEM forwarding active against the held result.
        i_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_forward_a = 2'b10; i_rs_data = $urandom; i_rt_data = $urandom;
            i_alu_op = 4'(i); i_rd = 5'(20 + i); {i_regwrite, i_memread} = 2'b11;
            tick_check($sformatf("stall%0d", i));
        end
        i_stall = 1'b0; i_forward_a = 2'b10; i_alu_op = 4'd0; i_alu_src = 1'b1;
        i_imm = 32'd1; i_forward_b = 2'b00; i_rt_data = 32'd77; i_rd = 5'd21;
        {i_regwrite, i_memread, i_memwrite, i_memtoreg} = 4'b1010;
        m_alu = 32'h1234_0001; m_store = 32'd77; m_rd = 5'd21; m_ctl = 4'b1010;
        tick_check("fwd_after_stall");

        i_stall = 1'b1; i_flush = 1'b1;
        set_zero_model();
        tick_check("flush_stall");
        i_stall = 1'b0; i_flush = 1'b0;
        apply_vec(vecs[0], 4'b0101);
        m_alu = 32'd12; m_store = 32'd7; m_rd = 5'd1; m_ctl = 4'b0101;
        tick_check("reload");
        i_stall = 1'b1; i_rst_n = 1'b0;
        set_zero_model();
        tick_check("reset_stall");
        i_stall = 1'b0; i_rst_n = 1'b1;
        apply_vec(vecs[7], 4'b1100);
        m_alu = 32'h8000_0000; m_store = 32'd1; m_rd = 5'd8; m_ctl = 4'b1100;
        tick_check("post_reset");

        for (int n = 0; n < 400; n++) begin
            i_forward_a = 2'($urandom); i_forward_b = 2'($urandom);
            i_rs_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            i_rt_data = $urandom; i_imm = $urandom; i_wb_data = $urandom;
            i_shamt = 5'($urandom); i_alu_op = 4'($urandom); i_alu_src = 1'($urandom);
            i_rd = 5'($urandom);
            {i_regwrite, i_memread, i_memwrite, i_memtoreg} = 4'($urandom);
            rst = ($urandom_range(0, 39) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 5) == 0);
            i_rst_n = rst; i_flush = fl; i_stall = st;
            a   = ref_sel(i_forward_a, i_rs_data, m_alu, i_wb_data);
            rtf = ref_sel(i_forward_b, i_rt_data, m_alu, i_wb_data);
            b   = i_alu_src ? i_imm : rtf;
            if (!rst || fl) begin
                set_zero_model();
            end else if (!st) begin
                m_alu = ref_alu(i_alu_op, a, b, i_shamt);
                m_store = rtf; m_rd = i_rd;
                m_ctl = {i_regwrite, i_memread, i_memwrite, i_memtoreg};
            end
            tick_check($sformatf("rnd%0d op%0d", n, i_alu_op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
- REQ-001 SHALL have i_clk, input, 1, single clock; all state updates on its rising edge.
- REQ-002 SHALL have i_rst_n, input, 1, reset; synchronous, active-low.
- REQ-003 SHALL have i_forward_a, i_forward_b, input, 2 each, operand select codes from the forwarding unit: 00 register file, 10 EX/MEM, 01 MEM/WB.
- REQ-004 SHALL have i_rs_data, i_rt_data, i_imm, i_wb_data, input, 32 each: register-file operands, sign-extended immediate, and MEM/WB write-back value.
- REQ-005 SHALL have i_shamt, input, 5, shift amount.
- REQ-006 SHALL have i_alu_op, input, 4, operation code.
- REQ-007 SHALL have i_alu_src, input, 1: 0 selects forwarded rt as B, 1 selects i_imm.
- REQ-008 SHALL have i_rd, input, 5, destination register index.
- REQ-009 SHALL have i_regwrite, i_memread, i_memwrite, i_memtoreg, input, 1 each: control bits passed to EX/MEM.
- REQ-010 SHALL have i_stall, i_flush, input, 1 each: hold or bubble the EX/MEM register.
- REQ-011 SHALL have o_alu_result, o_store_data, output, 32 each: registered ALU result and forwarded rt.
- REQ-012 SHALL have o_rd, output, 5, and o_regwrite, o_memread, o_memwrite, o_memtoreg, output, 1 each: registered EX/MEM fields.

Function
- REQ-013 Operand A SHALL be i_rs_data for 00, o_alu_result for 10, i_wb_data for 01, and i_rs_data for 11.
- REQ-014 Forwarded rt SHALL use the same selection rule on i_forward_b; B SHALL be forwarded rt when i_alu_src=0 and i_imm when i_alu_src=1.
- REQ-015 ALU ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 0/1), 7 SLTU, 8 SLL B by i_shamt, 9 SRL, 10 SRA, 11 SLLV B by A[4:0], 12 SRLV, 13 SRAV, 14 LUI (B<<16), 15 result 0.
- REQ-016 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag or trap.
- REQ-017 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on the outputs after edge N.
- REQ-018 o_store_data SHALL register forwarded rt regardless of i_alu_src.
- REQ-019 With i_stall=1 and i_flush=0, all outputs SHALL hold their values.
- REQ-020 With i_flush=1, the next edge SHALL load a bubble: all control outputs 0, o_rd 0, data outputs 0; flush SHALL override stall.
- REQ-021 Forward code 10 SHALL use the currently registered o_alu_result, including when the register is held by a stall.

Reset
- REQ-022 With i_rst_n=0 at a rising edge, every output SHALL be 0 after that edge, overriding stall and flush.
- REQ-023 Reset asserted mid-stream SHALL discard the in-flight instruction; the first post-reset edge SHALL capture fresh inputs.

Structure
- REQ-024 A shared package SHALL hold the ALU op codes, the forward select codes (00/10/01), and the data and register-index width constants.
- REQ-025 The combinational ALU SHALL be a separate sub-module, alu, instantiated once.

Verification
- REQ-026 Case 1: rs=5, rt=7, fwd 00/00, op ADD, after one edge -> o_alu_result=12, o_store_data=7.
- REQ-027 Case 2: back-to-back; first result 12, then fwd_a=10, rt=3, op SUB -> 9. Then fwd_b=01, wb=0xFFFF_FFFF, rs=1, op SLT -> 0. Repeat with op SLTU -> 1.
- REQ-028 Case 3: rt=0x8000_0000, shamt=4; SRA -> 0xF800_0000, SRL -> 0x0800_0000. SLLV with rs=33 -> 0x0000_0000 (shift by 1).
- REQ-029 Case 4: ADD of 0x7FFF_FFFF and 1 -> 0x8000_0000, no other effect. LUI with imm=0x0000_1234 and alu_src=1 -> 0x1234_0000.
- REQ-030 Case 5: stall two cycles with changing inputs -> outputs unchanged. Flush with stall -> all zero. Reset during stall -> all zero.
